// File: rtl/ddr_pkg.sv
// Shared DDR column-command types and default timing constants.
// Used by the CAS scheduler and the read/write data-timing FSM.
package ddr_pkg;

  typedef enum logic [2:0] {
    RD  = 3'd0,
    RDA = 3'd1,
    WR  = 3'd2,
    WRA = 3'd3
  } cas_cmd_t;

  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_RD   = 2'd1,
    SCH_WR   = 2'd2
  } sched_state_t;

  localparam int unsigned TCCD_DEF = 4;
  localparam int unsigned TWTR_DEF = 12;
  localparam int unsigned TRTW_DEF = 8;

  function automatic cas_cmd_t cas_cmd(input logic is_wr, input logic ap);
    cas_cmd_t cmd;
    unique case ({is_wr, ap})
      2'b00:   cmd = RD;
      2'b01:   cmd = RDA;
      2'b10:   cmd = WR;
      default: cmd = WRA;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/gap_counter.sv
// Loadable down-counter that saturates at zero; `zero` flags an expired gap.
module gap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ddr_cas_scheduler.sv
// Column-command arbiter: picks one RD/WR per slot subject to tCCD spacing,
// bus turnaround gaps and a write-starvation limit on read streaks.
module ddr_cas_scheduler
  import ddr_pkg::*;
#(
  parameter int unsigned TCCD       = TCCD_DEF,
  parameter int unsigned TWTR_GAP   = TWTR_DEF,
  parameter int unsigned TRTW_GAP   = TRTW_DEF,
  parameter int unsigned STARVE_LIM = 8,
  parameter int unsigned BANK_W     = 4
) (
  input  logic              CK_t,
  input  logic              reset,
  input  logic              sched_en,
  input  logic              rd_valid,
  input  logic              rd_ap,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              rd_ready,
  input  logic              wr_valid,
  input  logic              wr_ap,
  input  logic [BANK_W-1:0] wr_bank,
  output logic              wr_ready,
  output logic              cas_rdy,
  output cas_cmd_t          cas_req,
  output logic [BANK_W-1:0] cas_bank,
  output logic              sched_busy
);

  localparam int unsigned TurnMax = (TWTR_GAP > TRTW_GAP) ? TWTR_GAP : TRTW_GAP;
  localparam int unsigned GapMax  = (TurnMax > TCCD) ? TurnMax : TCCD;
  // Largest load value is GapMax-1.
  localparam int unsigned CntW    = (GapMax < 2) ? 1 : $clog2(GapMax);
  localparam int unsigned StreakW = $clog2(STARVE_LIM + 1);

  localparam logic [CntW-1:0]    SameLoad = CntW'(TCCD - 1);
  localparam logic [CntW-1:0]    RtwLoad  = CntW'(TRTW_GAP - 1);
  localparam logic [CntW-1:0]    WtrLoad  = CntW'(TWTR_GAP - 1);
  localparam logic [StreakW-1:0] StreakLim = StreakW'(STARVE_LIM);

  sched_state_t        state;
  logic [StreakW-1:0]  rd_streak;
  logic [CntW-1:0]     same_cnt;
  logic [CntW-1:0]     turn_cnt;
  logic [CntW-1:0]     turn_load;
  logic                same_zero;
  logic                turn_zero;
  logic                rd_elig;
  logic                wr_elig;
  logic                starve;
  logic                accept;

  assign rd_elig = sched_en && same_zero && (state != SCH_WR || turn_zero);
  assign wr_elig = sched_en && same_zero && (state != SCH_RD || turn_zero);
  // Starvation blocks reads even while the waiting write is still ineligible.
  assign starve  = wr_valid && (rd_streak == StreakLim);

  assign rd_ready = !reset && rd_valid && rd_elig && !starve;
  assign wr_ready = !reset && wr_valid && wr_elig && !rd_ready;
  assign accept   = rd_ready || wr_ready;

  assign turn_load  = rd_ready ? RtwLoad : WtrLoad;
  assign sched_busy = !(same_zero && turn_zero);

  gap_counter #(
    .W(CntW)
  ) u_same_cnt (
    .clk     (CK_t),
    .rst     (reset),
    .load    (accept),
    .load_val(SameLoad),
    .count   (same_cnt),
    .zero    (same_zero)
  );

  gap_counter #(
    .W(CntW)
  ) u_turn_cnt (
    .clk     (CK_t),
    .rst     (reset),
    .load    (accept),
    .load_val(turn_load),
    .count   (turn_cnt),
    .zero    (turn_zero)
  );

  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state     <= SCH_IDLE;
      rd_streak <= '0;
      cas_rdy   <= 1'b0;
      cas_req   <= RD;
      cas_bank  <= '0;
    end else begin
      cas_rdy <= accept;
      if (rd_ready) begin
        state    <= SCH_RD;
        cas_req  <= cas_cmd(1'b0, rd_ap);
        cas_bank <= rd_bank;
        // Streak only counts reads that overtook a waiting write.
        if (!wr_valid) begin
          rd_streak <= '0;
        end else if (rd_streak != StreakLim) begin
          rd_streak <= rd_streak + 1'b1;
        end
      end else if (wr_ready) begin
        state     <= SCH_WR;
        cas_req   <= cas_cmd(1'b1, wr_ap);
        cas_bank  <= wr_bank;
        rd_streak <= '0;
      end else if (same_zero && turn_zero) begin
        state <= SCH_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ddr_cas_scheduler.sv
// Scoreboard bench: each scenario queues the CAS issues it expects (cycle, command, bank)
// and a negedge monitor pops and compares them as cas_rdy pulses appear.
module tb_ddr_cas_scheduler;
  import ddr_pkg::*;

  localparam int unsigned BW = 4;

  logic          CK_t = 1'b0;
  logic          reset = 1'b1;
  logic          sched_en;
  logic          rd_valid, rd_ap, wr_valid, wr_ap;
  logic [BW-1:0] rd_bank, wr_bank;
  logic          rd_ready, wr_ready, cas_rdy, sched_busy;
  cas_cmd_t      cas_req;
  logic [BW-1:0] cas_bank;

  ddr_cas_scheduler #(
    .TCCD      (4),
    .TWTR_GAP  (12),
    .TRTW_GAP  (8),
    .STARVE_LIM(8),
    .BANK_W    (BW)
  ) dut (
    .CK_t      (CK_t),
    .reset     (reset),
    .sched_en  (sched_en),
    .rd_valid  (rd_valid),
    .rd_ap     (rd_ap),
    .rd_bank   (rd_bank),
    .rd_ready  (rd_ready),
    .wr_valid  (wr_valid),
    .wr_ap     (wr_ap),
    .wr_bank   (wr_bank),
    .wr_ready  (wr_ready),
    .cas_rdy   (cas_rdy),
    .cas_req   (cas_req),
    .cas_bank  (cas_bank),
    .sched_busy(sched_busy)
  );

  always #5 CK_t = ~CK_t;

  int unsigned cyc = 0;
  always @(posedge CK_t) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    cas_cmd_t      req;
    logic [BW-1:0] bank;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge CK_t);
    #1;
  endtask

  task automatic clr();
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    rd_ap    = 1'b0;
    wr_ap    = 1'b0;
  endtask

  task automatic push(input int unsigned at, input cas_cmd_t c, input logic [BW-1:0] b);
    exp_t e;
    e.cyc  = at;
    e.req  = c;
    e.bank = b;
    sb.push_back(e);
  endtask

  task automatic drain();
    clr();
    repeat (16) step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("idle_busy", 32'(sched_busy), 32'd0);
  endtask

  // A cas_rdy sampled after edge N must match an entry queued for cycle N+1.
  always @(negedge CK_t) begin
    exp_t e;
    if (!reset) begin
      check("one_ready", 32'(rd_ready & wr_ready), 32'd0);
      if (cas_rdy) begin
        if (sb.size() == 0) begin
          check("unexp_cas", 32'(cas_rdy), 32'd0);
        end else begin
          e = sb.pop_front();
          check("cas_cyc", cyc, e.cyc);
          check("cas_req", 32'(cas_req), 32'(e.req));
          check("cas_bank", 32'(cas_bank), 32'(e.bank));
        end
      end
    end
  end

  int unsigned t0;

  initial begin
    sched_en = 1'b1;
    clr();
    rd_bank = '0;
    wr_bank = '0;
    repeat (3) step();

    // Reset values, readies gated while reset is held.
    rd_valid = 1'b1;
    wr_valid = 1'b1;
    #1;
    check("rst_cas_rdy", 32'(cas_rdy), 32'd0);
    check("rst_cas_req", 32'(cas_req), 32'(RD));
    check("rst_cas_bank", 32'(cas_bank), 32'd0);
    check("rst_busy", 32'(sched_busy), 32'd0);
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    clr();
    reset = 1'b0;
    step();

    // Reads only: accepts at edges 0, 4, 8.
    t0 = cyc;
    rd_valid = 1'b1;
    rd_bank  = 4'd3;
    for (int i = 0; i < 3; i++) push(t0 + 1 + 4 * i, RD, 4'd3);
    #1;
    for (int k = 0; k < 10; k++) begin
      check("s1_rd_ready", 32'(rd_ready), 32'(k % 4 == 0));
      step();
    end
    drain();

    // WR at edge 0, RD must wait for the write-to-read gap.
    t0 = cyc;
    wr_valid = 1'b1;
    wr_bank  = 4'd6;
    push(t0 + 1, WR, 4'd6);
    push(t0 + 13, RD, 4'd1);
    step();
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_bank  = 4'd1;
    #1;
    for (int k = 1; k <= 12; k++) begin
      check("s2_rd_ready", 32'(rd_ready), 32'(k == 12));
      step();
    end
    drain();

    // RD at edge 0, WR must wait for the read-to-write gap.
    t0 = cyc;
    rd_valid = 1'b1;
    rd_bank  = 4'd2;
    push(t0 + 1, RD, 4'd2);
    push(t0 + 9, WR, 4'd8);
    step();
    rd_valid = 1'b0;
    wr_valid = 1'b1;
    wr_bank  = 4'd8;
    #1;
    for (int k = 1; k <= 8; k++) begin
      check("s2_wr_ready", 32'(wr_ready), 32'(k == 8));
      step();
    end
    drain();

    // Both valid: 8 reads, then starvation forces the write at edge 36.
    t0 = cyc;
    rd_valid = 1'b1;
    rd_bank  = 4'd5;
    wr_valid = 1'b1;
    wr_bank  = 4'd9;
    for (int i = 0; i < 8; i++) push(t0 + 1 + 4 * i, RD, 4'd5);
    push(t0 + 37, WR, 4'd9);
    push(t0 + 49, RD, 4'd5);
    #1;
    for (int k = 0; k <= 48; k++) begin
      check("s3_rd_ready", 32'(rd_ready), 32'((k % 4 == 0 && k <= 28) || k == 48));
      check("s3_wr_ready", 32'(wr_ready), 32'(k == 36));
      step();
      if (k == 36) begin
        wr_valid = 1'b0;
        #1;
      end
    end
    drain();

    // Auto-precharge variants, and cas_rdy is a single-cycle strobe.
    t0 = cyc;
    rd_valid = 1'b1;
    rd_ap    = 1'b1;
    rd_bank  = 4'd2;
    push(t0 + 1, RDA, 4'd2);
    step();
    clr();
    step();
    check("s4_rda_width", 32'(cas_rdy), 32'd0);
    drain();
    t0 = cyc;
    wr_valid = 1'b1;
    wr_ap    = 1'b1;
    wr_bank  = 4'd7;
    push(t0 + 1, WRA, 4'd7);
    step();
    clr();
    step();
    check("s4_wra_width", 32'(cas_rdy), 32'd0);
    drain();

    // sched_en low blocks issue while counters keep draining.
    t0 = cyc;
    rd_valid = 1'b1;
    rd_bank  = 4'd4;
    push(t0 + 1, RD, 4'd4);
    step();
    sched_en = 1'b0;
    wr_valid = 1'b1;
    wr_bank  = 4'd1;
    #1;
    for (int k = 1; k <= 10; k++) begin
      check("s5_rd_blocked", 32'(rd_ready), 32'd0);
      check("s5_wr_blocked", 32'(wr_ready), 32'd0);
      step();
    end
    check("s5_busy", 32'(sched_busy), 32'd0);
    sched_en = 1'b1;
    #1;
    check("s5_reenable", 32'(rd_ready), 32'd1);
    push(t0 + 12, RD, 4'd4);
    step();
    drain();

    // Reset right after an accept: the strobe is lost, turnaround forgotten.
    rd_valid = 1'b1;
    rd_ap    = 1'b1;
    rd_bank  = 4'd3;
    @(posedge CK_t);
    #1;
    reset = 1'b1;
    #1;
    check("s6_cas_rdy", 32'(cas_rdy), 32'd0);
    check("s6_cas_req", 32'(cas_req), 32'(RD));
    check("s6_cas_bank", 32'(cas_bank), 32'd0);
    check("s6_busy", 32'(sched_busy), 32'd0);
    check("s6_rd_ready", 32'(rd_ready), 32'd0);
    step();
    step();
    check("s6_hold_rdy", 32'(cas_rdy), 32'd0);
    clr();
    wr_valid = 1'b1;
    wr_bank  = 4'd4;
    reset    = 1'b0;
    t0 = cyc;
    #1;
    check("s6_wr_ready", 32'(wr_ready), 32'd1);
    push(t0 + 1, WR, 4'd4);
    step();
    drain();

    check("sb_final", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
